// File: rtl/eval_pkg.sv
// Shared definitions for the move-evaluation argmax path.
package eval_pkg;

  // Tie-rule selectors: TIE_LO lets the lower index win, TIE_HI the higher.
  localparam bit TIE_LO = 1'b1;
  localparam bit TIE_HI = 1'b0;

  // Default configuration: 64 squares, 6-bit scores.
  localparam int DEF_W  = 6;
  localparam int DEF_IW = 6;

  // Node record for the default configuration; modules with other widths
  // build the same {score, index, any} layout locally.
  typedef struct packed {
    logic [DEF_W-1:0]  score;
    logic [DEF_IW-1:0] index;
    logic              any;
  } node_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/score_argmax_pipe_node.sv
// One tree node: combinational winner pick between two children plus an
// enabled stage register. Left child always carries the lower indices.
module argmax_node import eval_pkg::*; #(
  parameter int W       = 6,
  parameter int IW      = 6,
  parameter bit TIE_LOW = TIE_LO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  l_score,
  input  logic [IW-1:0] l_index,
  input  logic          l_any,
  input  logic [W-1:0]  r_score,
  input  logic [IW-1:0] r_index,
  input  logic          r_any,
  output logic [W-1:0]  score,
  output logic [IW-1:0] index,
  output logic          any
);

  logic          take_r;
  logic [W-1:0]  nxt_score;
  logic [IW-1:0] nxt_index;
  logic          nxt_any;

  // Winner select; an empty pair collapses to {0,0,0}.
  always_comb begin
    take_r    = 1'b0;
    nxt_score = '0;
    nxt_index = '0;
    nxt_any   = 1'b0;
    if (l_any && r_any)
      take_r = (r_score > l_score) || ((r_score == l_score) && (TIE_LOW == TIE_HI));
    else
      take_r = r_any;
    if (l_any || r_any) begin
      nxt_any   = 1'b1;
      nxt_score = take_r ? r_score : l_score;
      nxt_index = take_r ? r_index : l_index;
    end
  end

  // Stage register, held while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
      index <= '0;
      any   <= 1'b0;
    end else if (en) begin
      score <= nxt_score;
      index <= nxt_index;
      any   <= nxt_any;
    end
  end

endmodule

// File: rtl/score_argmax_pipe.sv
// Pipelined max-reduction tree over N masked candidate scores.
// The tree is stored heap-style: node k has children 2k (lower indices) and
// 2k+1; leaves sit at P..2P-1 and are driven straight from the inputs, so
// the L internal levels give exactly L register stages.
module score_argmax_pipe import eval_pkg::*; #(
  parameter  int N       = 64,
  parameter  int W       = 6,
  parameter  bit TIE_LOW = TIE_LO,
  localparam int IW      = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_score,
  input  logic [N-1:0]   in_mask,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_score,
  output logic [IW-1:0]  out_index,
  output logic           out_any
);

  localparam int L = IW;
  localparam int P = 1 << L;

  logic [W-1:0]  t_score [1:2*P-1];
  logic [IW-1:0] t_index [1:2*P-1];
  logic          t_any   [1:2*P-1];

  logic          advance;
  logic          accept;
  logic [L:1]    vld_pipe;

  // Whole pipeline moves together unless a held result is not taken.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && in_ready;

  // Leaves; pad slots are permanently masked out so they never win.
  for (genvar i = 0; i < P; i++) begin : gen_leaf
    if (i < N) begin : g_real
      assign t_score[P+i] = in_score[i*W +: W];
      assign t_any[P+i]   = in_mask[i];
    end else begin : g_pad
      assign t_score[P+i] = '0;
      assign t_any[P+i]   = 1'b0;
    end
    assign t_index[P+i] = IW'(i);
  end

  for (genvar k = 1; k < P; k++) begin : gen_node
    argmax_node #(.W(W), .IW(IW), .TIE_LOW(TIE_LOW)) u_node (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .l_score (t_score[2*k]),
      .l_index (t_index[2*k]),
      .l_any   (t_any[2*k]),
      .r_score (t_score[2*k+1]),
      .r_index (t_index[2*k+1]),
      .r_any   (t_any[2*k+1]),
      .score   (t_score[k]),
      .index   (t_index[k]),
      .any     (t_any[k])
    );
  end

  // Valid shift register; bubbles travel with the data and are not collapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= accept;
      for (int s = 2; s <= L; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign out_valid = vld_pipe[L];
  assign out_score = t_score[1];
  assign out_index = t_index[1];
  assign out_any   = t_any[1];

endmodule

// File: tb/tb_score_argmax_pipe.sv
// Self-checking bench: three instances (64/6 low-tie, 64/6 high-tie sharing
// the same inputs, 10/8 low-tie), a scoreboard fed by a plain linear-scan
// argmax model, and directed literal cases for the interesting vectors.
module tb_score_argmax_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid0, out_ready0;
  logic [383:0] in_score0;
  logic [63:0]  in_mask0;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [5:0]   out_score0, out_score1, out_index0, out_index1;
  logic         out_any0, out_any1;

  logic         in_valid2, out_ready2;
  logic [79:0]  in_score2;
  logic [9:0]   in_mask2;
  logic         in_ready2, out_valid2;
  logic [7:0]   out_score2;
  logic [3:0]   out_index2;
  logic         out_any2;

  score_argmax_pipe #(.N(64), .W(6), .TIE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_score(in_score0), .in_mask(in_mask0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_score(out_score0), .out_index(out_index0),
    .out_any(out_any0));

  score_argmax_pipe #(.N(64), .W(6), .TIE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready1),
    .in_score(in_score0), .in_mask(in_mask0), .out_valid(out_valid1),
    .out_ready(out_ready0), .out_score(out_score1), .out_index(out_index1),
    .out_any(out_any1));

  score_argmax_pipe #(.N(10), .W(8), .TIE_LOW(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_score(in_score2), .in_mask(in_mask2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_score(out_score2), .out_index(out_index2),
    .out_any(out_any2));

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int mode   = 0;   // 0: out_ready=1, 1: 1,0,0 pattern, 2: random
  int ph     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: scan candidates in index order, keep the best masked-in one.
  function automatic logic [12:0] ref64(input logic [383:0] sc, input logic [63:0] m, input bit tl);
    logic [5:0] bs, bi;
    logic       ba;
    bs = '0; bi = '0; ba = 1'b0;
    for (int i = 0; i < 64; i++)
      if (m[i] && (!ba || sc[i*6 +: 6] > bs || (sc[i*6 +: 6] == bs && !tl))) begin
        bs = sc[i*6 +: 6]; bi = 6'(i); ba = 1'b1;
      end
    return {bs, bi, ba};
  endfunction

  function automatic logic [12:0] ref10(input logic [79:0] sc, input logic [9:0] m);
    logic [7:0] bs;
    logic [3:0] bi;
    logic       ba;
    bs = '0; bi = '0; ba = 1'b0;
    for (int i = 0; i < 10; i++)
      if (m[i] && (!ba || sc[i*8 +: 8] > bs)) begin
        bs = sc[i*8 +: 8]; bi = 4'(i); ba = 1'b1;
      end
    return {bs, bi, ba};
  endfunction

  typedef struct { logic [12:0] e0; logic [12:0] e1; int acc; bit lat; } ent64_t;
  typedef struct { logic [12:0] e; int acc; bit lat; } ent10_t;
  ent64_t q0[$];
  ent10_t q2[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready pattern.
  initial begin
    out_ready0 = 1'b1;
    out_ready2 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (mode)
        1:       out_ready0 = (ph % 3 == 0);
        2:       out_ready0 = 1'($urandom_range(0, 1));
        default: out_ready0 = 1'b1;
      endcase
      out_ready2 = out_ready0;
    end
  end

  // Compare process: every cycle, on the falling edge.
  bit         st0 = 1'b0, st2 = 1'b0;
  logic [5:0] hs0, hi0;
  logic [7:0] hs2;
  logic [3:0] hi2;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q0.delete(); q2.delete();
      st0 = 1'b0; st2 = 1'b0;
    end else begin
      chk("in_ready0_rule", 32'(in_ready0), 32'(!(out_valid0 && !out_ready0)));
      chk("pair_in_ready", 32'(in_ready1), 32'(in_ready0));
      chk("pair_valid", 32'(out_valid1), 32'(out_valid0));
      if (st0) begin
        chk("hold0_valid", 32'(out_valid0), 32'd1);
        chk("hold0_score", 32'(out_score0), 32'(hs0));
        chk("hold0_index", 32'(out_index0), 32'(hi0));
      end
      if (out_valid0) begin
        if (q0.size() == 0) chk("spurious_out0", 32'(out_valid0), 32'd0);
        else begin
          chk("score0", 32'(out_score0), 32'(q0[0].e0[12:7]));
          chk("index0", 32'(out_index0), 32'(q0[0].e0[6:1]));
          chk("any0",   32'(out_any0),   32'(q0[0].e0[0]));
          chk("score1", 32'(out_score1), 32'(q0[0].e1[12:7]));
          chk("index1", 32'(out_index1), 32'(q0[0].e1[6:1]));
          chk("any1",   32'(out_any1),   32'(q0[0].e1[0]));
          if (q0[0].lat) chk("latency0", 32'(cyc - q0[0].acc), 32'd6);
          if (out_ready0) void'(q0.pop_front());
        end
      end
      st0 = out_valid0 && !out_ready0;
      hs0 = out_score0; hi0 = out_index0;
      if (in_valid0 && in_ready0)
        q0.push_back('{ref64(in_score0, in_mask0, 1'b1), ref64(in_score0, in_mask0, 1'b0), cyc, mode == 0});

      chk("in_ready2_rule", 32'(in_ready2), 32'(!(out_valid2 && !out_ready2)));
      if (st2) begin
        chk("hold2_valid", 32'(out_valid2), 32'd1);
        chk("hold2_score", 32'(out_score2), 32'(hs2));
        chk("hold2_index", 32'(out_index2), 32'(hi2));
      end
      if (out_valid2) begin
        if (q2.size() == 0) chk("spurious_out2", 32'(out_valid2), 32'd0);
        else begin
          chk("score2", 32'(out_score2), 32'(q2[0].e[12:5]));
          chk("index2", 32'(out_index2), 32'(q2[0].e[4:1]));
          chk("any2",   32'(out_any2),   32'(q2[0].e[0]));
          if (q2[0].lat) chk("latency2", 32'(cyc - q2[0].acc), 32'd4);
          if (out_ready2) void'(q2.pop_front());
        end
      end
      st2 = out_valid2 && !out_ready2;
      hs2 = out_score2; hi2 = out_index2;
      if (in_valid2 && in_ready2)
        q2.push_back('{ref10(in_score2, in_mask2), cyc, mode == 0});
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic send0(input logic [383:0] sc, input logic [63:0] m);
    bit ok;
    ok = 1'b0;
    in_score0 = sc; in_mask0 = m; in_valid0 = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready0;
      @(posedge clk);
      #1;
    end
    in_valid0 = 1'b0;
    if (!ok) chk("send0_timeout", 32'd0, 32'd1);
  endtask

  task automatic send2(input logic [79:0] sc, input logic [9:0] m);
    bit ok;
    ok = 1'b0;
    in_score2 = sc; in_mask2 = m; in_valid2 = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready2;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    if (!ok) chk("send2_timeout", 32'd0, 32'd1);
  endtask

  logic [5:0] ws0, wi0, wi1;
  logic       wa0;
  logic [7:0] ws2;
  logic [3:0] wi2;
  logic       wa2;
  task automatic wait_out(input int which);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = (which == 0) ? out_valid0 : out_valid2;
    end
    ws0 = out_score0; wi0 = out_index0; wa0 = out_any0; wi1 = out_index1;
    ws2 = out_score2; wi2 = out_index2; wa2 = out_any2;
    if (!ok) chk("wait_out_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(posedge clk);
      #1;
      ok = (q0.size() == 0) && (q2.size() == 0) && !out_valid0 && !out_valid2;
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand64(output logic [383:0] sc, output logic [63:0] m);
    int k;
    k = $urandom_range(0, 3);
    for (int i = 0; i < 64; i++)
      sc[i*6 +: 6] = (k == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
    case ($urandom_range(0, 3))
      0: m = '1;
      1: m = {$urandom, $urandom};
      2: begin
        m = '0;
        for (int i = 0; i < 64; i++) if ($urandom_range(0, 7) == 0) m[i] = 1'b1;
      end
      default: m = {$urandom, $urandom} & {$urandom, $urandom};
    endcase
  endtask

  task automatic stream0(input int n, input bit gaps);
    logic [383:0] sc;
    logic [63:0]  m;
    for (int v = 0; v < n; v++) begin
      rand64(sc, m);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send0(sc, m);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [383:0] sc;
  logic [63:0]  m;
  logic [79:0]  sc2;
  logic [12:0]  r13;

  initial begin
    in_valid0 = 1'b0; in_score0 = '0; in_mask0 = '0;
    in_valid2 = 1'b0; in_score2 = '0; in_mask2 = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_out_valid0", 32'(out_valid0), 32'd0);
    chk("rst_out_score0", 32'(out_score0), 32'd0);
    chk("rst_out_index0", 32'(out_index0), 32'd0);
    chk("rst_out_any0",   32'(out_any0),   32'd0);
    chk("rst_in_ready0",  32'(in_ready0),  32'd1);
    chk("rst_out_valid2", 32'(out_valid2), 32'd0);
    chk("rst_in_ready2",  32'(in_ready2),  32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Distinct scores.
    for (int i = 0; i < 64; i++) sc[i*6 +: 6] = 6'(i);
    sc[37*6 +: 6] = 6'd63;
    sc[63*6 +: 6] = 6'd10;
    m = '1;
    r13 = ref64(sc, m, 1'b1);
    chk("model_distinct", 32'(r13), 32'({6'd63, 6'd37, 1'b1}));
    send0(sc, m);
    wait_out(0);
    chk("distinct_score", 32'(ws0), 32'd63);
    chk("distinct_index", 32'(wi0), 32'd37);
    chk("distinct_any",   32'(wa0), 32'd1);

    // Tie between 5 and 50.
    sc = '0;
    sc[5*6 +: 6]  = 6'd40;
    sc[50*6 +: 6] = 6'd40;
    r13 = ref64(sc, m, 1'b0);
    chk("model_tie_high", 32'(r13), 32'({6'd40, 6'd50, 1'b1}));
    send0(sc, m);
    wait_out(0);
    chk("tie_score",      32'(ws0), 32'd40);
    chk("tie_low_index",  32'(wi0), 32'd5);
    chk("tie_high_index", 32'(wi1), 32'd50);

    // Masked-out maximum.
    sc = '0;
    sc[9*6 +: 6] = 6'd60;
    sc[2*6 +: 6] = 6'd20;
    m = 64'h4;
    r13 = ref64(sc, m, 1'b1);
    chk("model_mask", 32'(r13), 32'({6'd20, 6'd2, 1'b1}));
    send0(sc, m);
    wait_out(0);
    chk("mask_score", 32'(ws0), 32'd20);
    chk("mask_index", 32'(wi0), 32'd2);

    // Nothing masked in.
    send0(sc, 64'h0);
    wait_out(0);
    chk("none_any",   32'(wa0), 32'd0);
    chk("none_score", 32'(ws0), 32'd0);
    chk("none_index", 32'(wi0), 32'd0);

    // Random streaming, full throughput then backpressure.
    stream0(40, 1'b0);
    drain();
    mode = 1;
    stream0(10, 1'b0);
    drain();
    mode = 2;
    stream0(40, 1'b1);
    drain();
    mode = 0;
    @(posedge clk);
    #1;

    // Reset with vectors in flight.
    stream0(3, 1'b0);
    wait_out(0);
    chk("pre_rst_valid", 32'(out_valid0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid0", 32'(out_valid0), 32'd0);
    chk("midrst_valid1", 32'(out_valid1), 32'd0);
    chk("midrst_score0", 32'(out_score0), 32'd0);
    chk("midrst_index0", 32'(out_index0), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    sc = '0;
    sc[5*6 +: 6]  = 6'd40;
    sc[50*6 +: 6] = 6'd40;
    send0(sc, '1);
    wait_out(0);
    chk("postrst_index0", 32'(wi0), 32'd5);
    chk("postrst_index1", 32'(wi1), 32'd50);
    drain();

    // Non-power-of-two tree.
    for (int i = 0; i < 10; i++) sc2[i*8 +: 8] = 8'($urandom_range(0, 254));
    sc2[9*8 +: 8] = 8'd255;
    r13 = ref10(sc2, 10'h3FF);
    chk("model10_top", 32'(r13), 32'({8'd255, 4'd9, 1'b1}));
    send2(sc2, 10'h3FF);
    wait_out(2);
    chk("n10_score", 32'(ws2), 32'd255);
    chk("n10_index", 32'(wi2), 32'd9);
    for (int i = 0; i < 9; i++) sc2[i*8 +: 8] = 8'($urandom_range(0, 199));
    sc2[3*8 +: 8] = 8'd200;
    r13 = ref10(sc2, 10'h1FF);
    chk("model10_mask", 32'(r13), 32'({8'd200, 4'd3, 1'b1}));
    send2(sc2, 10'h1FF);
    wait_out(2);
    chk("n10m_score", 32'(ws2), 32'd200);
    chk("n10m_index", 32'(wi2), 32'd3);
    chk("n10m_any",   32'(wa2), 32'd1);

    mode = 2;
    for (int v = 0; v < 30; v++) begin
      for (int i = 0; i < 10; i++) sc2[i*8 +: 8] = 8'($urandom_range(0, 7));
      send2(sc2, 10'($urandom));
    end
    drain();
    mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
